// File: rtl/pulse_meas.sv
// Pulse-width capture: counts clk cycles that the (optionally synchronized) input is high,
// latches the result with sticky done/ovf/lost status, readable over an address-match bus.
module pulse_meas #(
  parameter int CNT_W   = 32,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_width_addr,
  input  logic [31:0] i_stat_addr,
  input  logic        i_rd,
  input  logic [31:0] i_raddr,
  output logic [31:0] o_rdata,
  output logic        o_rdata_vld,
  input  logic        i_pulse_in,
  output logic        o_meas_done
);

  // state | meaning
  // IDLE  | waiting for a rising edge of the conditioned input
  // MEAS  | input high, counting cycles until the falling edge
  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_width;
  logic             r_ovf_pend;
  logic             r_done;
  logic             r_ovf;
  logic             r_lost;
  logic             r_p_d;

  logic w_p_s;
  logic w_rise;
  logic w_fall;
  logic w_rd_width;
  logic w_rd_stat;
  logic w_cnt_max;

  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] r_sync;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], i_pulse_in};
      end
      assign w_p_s = r_sync[1];
    end else begin : g_nosync
      assign w_p_s = i_pulse_in;
    end
  endgenerate

  assign w_rise     = w_p_s & ~r_p_d;
  assign w_fall     = ~w_p_s & r_p_d;
  // WIDTH decode has priority when both addresses alias, so nothing clears then
  assign w_rd_width = i_rd && (i_raddr == i_width_addr);
  assign w_rd_stat  = i_rd && (i_raddr == i_stat_addr) && !w_rd_width;
  assign w_cnt_max  = &r_cnt;

  assign o_meas_done = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_width     <= '0;
      r_ovf_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_lost      <= 1'b0;
      r_p_d       <= 1'b0;
      o_rdata     <= '0;
      o_rdata_vld <= 1'b0;
    end else begin
      r_p_d       <= w_p_s;
      o_rdata_vld <= w_rd_width | w_rd_stat;
      if (w_rd_width)     o_rdata <= 32'(r_width);
      else if (w_rd_stat) o_rdata <= {29'b0, r_lost, r_ovf, r_done};
      else                o_rdata <= '0;

      if (w_rd_stat) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
        r_lost <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MEAS;
            r_cnt   <= CNT_W'(1);
          end
        end
        MEAS: begin
          if (w_fall) begin
            // capture overrides a same-edge status clear; rdata above still shows old values
            r_state    <= IDLE;
            r_width    <= r_cnt;
            r_done     <= 1'b1;
            r_ovf      <= (r_ovf & ~w_rd_stat) | r_ovf_pend;
            r_lost     <= (r_lost & ~w_rd_stat) | r_done;
            r_ovf_pend <= 1'b0;
          end else if (w_cnt_max) begin
            r_ovf_pend <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas: three instances cover SYNC_EN=1/CNT_W=32, CNT_W=4, SYNC_EN=0.
module tb_pulse_meas;

  localparam logic [31:0] WA = 32'h0000_0010;
  localparam logic [31:0] SA = 32'h0000_0014;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] raddr = '0;
  logic        rd_a = 1'b0, rd_b = 1'b0, rd_c = 1'b0;
  logic        p_a = 1'b0, p_b = 1'b0, p_c = 1'b0;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        vld_a, vld_b, vld_c;
  logic        done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_meas #(.CNT_W(32), .SYNC_EN(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_width_addr(WA), .i_stat_addr(SA),
    .i_rd(rd_a), .i_raddr(raddr), .o_rdata(rdata_a), .o_rdata_vld(vld_a),
    .i_pulse_in(p_a), .o_meas_done(done_a));

  pulse_meas #(.CNT_W(4), .SYNC_EN(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_width_addr(WA), .i_stat_addr(SA),
    .i_rd(rd_b), .i_raddr(raddr), .o_rdata(rdata_b), .o_rdata_vld(vld_b),
    .i_pulse_in(p_b), .o_meas_done(done_b));

  pulse_meas #(.CNT_W(32), .SYNC_EN(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_width_addr(WA), .i_stat_addr(SA),
    .i_rd(rd_c), .i_raddr(raddr), .o_rdata(rdata_c), .o_rdata_vld(vld_c),
    .i_pulse_in(p_c), .o_meas_done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input int sel, input logic [31:0] addr,
                        output logic [31:0] data, output logic vld);
    raddr = addr;
    if (sel == 0) rd_a = 1'b1;
    else if (sel == 1) rd_b = 1'b1;
    else rd_c = 1'b1;
    tick();
    data = (sel == 0) ? rdata_a : (sel == 1) ? rdata_b : rdata_c;
    vld  = (sel == 0) ? vld_a   : (sel == 1) ? vld_b   : vld_c;
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
    raddr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    if ({rdata_a, vld_a, done_a} !== 34'd0) begin errors++; $display("FAIL reset_a got %h want 0", {rdata_a, vld_a, done_a}); end
    checks++;
    if ({rdata_b, vld_b, done_b} !== 34'd0) begin errors++; $display("FAIL reset_b got %h want 0", {rdata_b, vld_b, done_b}); end
    checks++;
    if ({rdata_c, vld_c, done_c} !== 34'd0) begin errors++; $display("FAIL reset_c got %h want 0", {rdata_c, vld_c, done_c}); end
    checks++;
    rst_n = 1'b1;
    repeat (3) tick();
    if (done_a !== 1'b0 || vld_a !== 1'b0) begin errors++; $display("FAIL idle_after_reset got done=%b vld=%b want 0 0", done_a, vld_a); end
    checks++;
  endtask

  task automatic test_basic_width();
    logic [31:0] d; logic v;
    p_a = 1'b1;
    repeat (5) tick();
    p_a = 1'b0;
    repeat (2) tick();
    if (done_a !== 1'b0) begin errors++; $display("FAIL done_early got %b want 0", done_a); end
    checks++;
    tick();
    if (done_a !== 1'b1) begin errors++; $display("FAIL done_3rd_edge got %b want 1", done_a); end
    checks++;
    rd_reg(0, WA, d, v);
    if (d !== 32'h5) begin errors++; $display("FAIL width5 got %h want 5", d); end
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL width5_vld got %b want 1", v); end
    checks++;
  endtask

  task automatic test_status_clear();
    logic [31:0] d; logic v;
    rd_reg(0, SA, d, v);
    if (d !== 32'h1 || v !== 1'b1) begin errors++; $display("FAIL stat1 got %h/%b want 1/1", d, v); end
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL done_cleared got %b want 0", done_a); end
    checks++;
    rd_reg(0, SA, d, v);
    if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL stat2 got %h/%b want 0/1", d, v); end
    checks++;
    rd_reg(0, WA, d, v);
    if (d !== 32'h5) begin errors++; $display("FAIL width_kept got %h want 5", d); end
    checks++;
  endtask

  task automatic test_saturate();
    logic [31:0] d; logic v;
    p_b = 1'b1;
    repeat (20) tick();
    p_b = 1'b0;
    repeat (3) tick();
    if (done_b !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", done_b); end
    checks++;
    rd_reg(1, WA, d, v);
    if (d !== 32'hF) begin errors++; $display("FAIL sat_width got %h want f", d); end
    checks++;
    rd_reg(1, SA, d, v);
    if (d !== 32'h3) begin errors++; $display("FAIL sat_stat got %h want 3", d); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    p_a = 1'b1; repeat (7) tick();
    p_a = 1'b0; repeat (4) tick();
    p_a = 1'b1; repeat (3) tick();
    p_a = 1'b0; repeat (4) tick();
    rd_reg(0, WA, d, v);
    if (d !== 32'h3) begin errors++; $display("FAIL b2b_width got %h want 3", d); end
    checks++;
    rd_reg(0, SA, d, v);
    if (d !== 32'h5) begin errors++; $display("FAIL b2b_stat got %h want 5", d); end
    checks++;
  endtask

  task automatic test_nosync_capture_read();
    logic [31:0] d; logic v;
    p_c = 1'b1;
    tick();
    if (done_c !== 1'b0) begin errors++; $display("FAIL ns_done_early got %b want 0", done_c); end
    checks++;
    p_c = 1'b0;
    rd_c = 1'b1; raddr = SA;
    tick();
    rd_c = 1'b0; raddr = '0;
    if (rdata_c !== 32'h0 || vld_c !== 1'b1) begin errors++; $display("FAIL ns_stat_same_edge got %h/%b want 0/1", rdata_c, vld_c); end
    checks++;
    if (done_c !== 1'b1) begin errors++; $display("FAIL ns_done_1st_edge got %b want 1", done_c); end
    checks++;
    rd_reg(2, WA, d, v);
    if (d !== 32'h1) begin errors++; $display("FAIL ns_width got %h want 1", d); end
    checks++;
    rd_reg(2, SA, d, v);
    if (d !== 32'h1) begin errors++; $display("FAIL ns_stat_after got %h want 1", d); end
    checks++;
  endtask

  task automatic test_unmatched_and_reset();
    logic [31:0] d; logic v;
    rd_reg(0, 32'h20, d, v);
    if (d !== 32'h0 || v !== 1'b0) begin errors++; $display("FAIL unmatched got %h/%b want 0/0", d, v); end
    checks++;
    p_a = 1'b1;
    repeat (2) tick();
    rd_a = 1'b1; raddr = WA;
    tick();
    rd_a = 1'b0; raddr = '0;
    if (rdata_a !== 32'h3 || vld_a !== 1'b1) begin errors++; $display("FAIL pre_reset_read got %h/%b want 3/1", rdata_a, vld_a); end
    checks++;
    rst_n = 1'b0;
    #1;
    if ({rdata_a, vld_a, done_a} !== 34'd0) begin errors++; $display("FAIL midpulse_reset got %h want 0", {rdata_a, vld_a, done_a}); end
    checks++;
    p_a = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    if (done_a !== 1'b0) begin errors++; $display("FAIL no_capture got %b want 0", done_a); end
    checks++;
    rd_reg(0, WA, d, v);
    if (d !== 32'h0) begin errors++; $display("FAIL width_after_reset got %h want 0", d); end
    checks++;
    p_a = 1'b1; repeat (6) tick();
    p_a = 1'b0; repeat (3) tick();
    if (done_a !== 1'b1) begin errors++; $display("FAIL post_reset_done got %b want 1", done_a); end
    checks++;
    rd_reg(0, WA, d, v);
    if (d !== 32'h6) begin errors++; $display("FAIL post_reset_width got %h want 6", d); end
    checks++;
    tick();
    if (vld_a !== 1'b0 || rdata_a !== 32'h0) begin errors++; $display("FAIL vld_one_cycle got %h/%b want 0/0", rdata_a, vld_a); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic_width();
    test_status_clear();
    test_saturate();
    test_back_to_back();
    test_nosync_capture_read();
    test_unmatched_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
Register-readable pulse-width capture block: the read-side counterpart of the register-write pulse generator.
- Measures the high time of an incoming pulse in clk cycles and latches the result.
- Raises a sticky done flag (usable as an IRQ level).
- Exposes width and status through the same 32-bit address-match bus style used by the MAC register blocks.
- Sits beside the pulse generator in the MAC and can loop back its output for self-test.

Parameters:
CNT_W, 32, width counter/result width (1..32); result zero-extended to 32 bits on rdata.
SYNC_EN, 1, 1 = pulse_in passes a 2-flop synchronizer; 0 = pulse_in used directly (must be synchronous to clk).

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
width_addr  input  32  address of WIDTH register (read-only)
stat_addr  input  32  address of STATUS register (read, clear-on-read)
rd  input  1  read strobe, one cycle per access
raddr  input  32  read address, qualified by rd
rdata  output  32  read data, registered
rdata_vld  output  1  1-cycle strobe, rdata valid
pulse_in  input  1  pulse to be measured
meas_done  output  1  level copy of STATUS.done

Behaviour:
Reset:
- rdata=0, rdata_vld=0, meas_done=0.
- Synchronizer flops, p_d, cnt, width_reg, done/ovf/lost all 0; FSM in IDLE.
- Reset asserted mid-pulse aborts the measurement with no capture.
- pulse_in high at reset release is seen as a rising edge (sync flops reset to 0).

Input path:
- p_s = pulse_in after 2 flops (SYNC_EN=1) or pulse_in itself (SYNC_EN=0).
- p_d = p_s delayed 1 cycle.
- rise = p_s & ~p_d; fall = ~p_s & p_d.

FSM, 2 states:
- IDLE: on rise -> MEAS, cnt<=1.
- MEAS, p_s high: cnt<=cnt+1, saturating at 2^CNT_W-1. An increment attempted at saturation sets ovf_pend.
- MEAS, fall -> IDLE; same edge: width_reg<=cnt, done<=1, ovf<=ovf|ovf_pend, ovf_pend<=0. If done was already 1, lost<=1 and width_reg is overwritten (newest wins).
- Result: width_reg = number of cycles p_s was high.
- Minimum measurable pulse is 1 cycle of p_s. With SYNC_EN=1, pulses shorter than 1 clk may be missed.

Latency:
- meas_done rises at the 3rd clk edge after pulse_in falls (SYNC_EN=1), 1st edge (SYNC_EN=0).

Read port:
- Registered, 1-cycle latency: rd at edge N gives rdata/rdata_vld at edge N+1.
- raddr==width_addr: rdata={0,width_reg}, rdata_vld=1. Does not clear status.
- raddr==stat_addr: rdata={29'b0,lost,ovf,done}, rdata_vld=1. done, ovf and lost clear on that same edge.
- width_addr==stat_addr: WIDTH decode wins, nothing clears.
- No match or rd=0: rdata=0, rdata_vld=0.
- STATUS read on the same edge as a capture: rdata returns the pre-capture values. The capture set wins, so done=1 afterwards. lost is set only if done was 1 before the edge; it also survives the clear.
- A read never affects measurement.

Test Plan:
1. SYNC_EN=1, pulse_in high exactly 5 clk -> meas_done=1 at 3rd edge after fall; WIDTH read gives rdata=0x5 with rdata_vld=1 one cycle after rd.
2. After test 1, STATUS read -> 0x1 and meas_done drops next cycle; second STATUS read -> 0x0; WIDTH read still 0x5.
3. CNT_W=4, pulse high 20 clk -> WIDTH=0xF, STATUS=0x3.
4. Two pulses (7 then 3 clk), no read in between -> WIDTH=0x3, STATUS=0x5.
5. SYNC_EN=0, 1-clk pulse -> meas_done at 1st edge after fall, WIDTH=0x1. Status read issued on the capture edge returns 0x0 and leaves done=1.
6. rd to unmatched address -> rdata_vld=0, rdata=0. rst_n pulsed low mid-pulse -> all outputs 0, no capture, next full pulse measured correctly.
